// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: FSM state encoding, parity mode, majority vote.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_t;

  // 2-of-3 vote used for every bit decision
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser, fall detector and 3-sample majority voter.
// Latency: rx_in reaches line after 2 clk; bit_maj is valid in the cycle phase == PRESCALE/2+1.
// Backpressure: none; free-running, follows the phase counter supplied by the FSM.
// Ports: clk, rst (async active-low), rx_in (raw line), phase (bit-phase counter),
//        line (synchronised line), fall (high-to-low on line), bit_maj (majority of the three samples).
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 16,
  parameter int PW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_in,
  input  logic [PW-1:0] phase,
  output logic          line,
  output logic          fall,
  output logic          bit_maj
);

  localparam int MID = PRESCALE / 2;

  logic sync1, sync2, line_prev;
  logic samp_a, samp_b;

  // Flops reset high so an idle line never looks like a start edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
    end else begin
      sync1     <= rx_in;
      sync2     <= sync1;
      line_prev <= sync2;
      if (phase == PW'(MID - 1)) samp_a <= sync2;
      if (phase == PW'(MID))     samp_b <= sync2;
    end
  end

  assign line    = sync2;
  assign fall    = line_prev & ~sync2;
  // Third sample is the live line value at phase MID+1, so the vote settles that cycle.
  assign bit_maj = maj3(samp_a, samp_b, sync2);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: start/data/parity/stop FSM with framing, parity and break flags.
// Latency: data_valid at t0 + PRESCALE/2 + 2 + F*PRESCALE, F = DATA_WIDTH + par_en + 1 + stop2.
// Backpressure: none; each frame is presented once as a one-cycle data_valid pulse.
// Ports: clk, rst (async active-low), rx_in (serial, idle high), par_en/par_typ/stop2 (frame format,
//        latched at the start edge), p_data/par_error/stop_error (held until next data_valid),
//        data_valid, break_det (one-cycle pulses).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_error,
  output logic                  stop_error,
  output logic                  break_det
);

  localparam int PW  = $clog2(PRESCALE);
  localparam int BW  = $clog2(DATA_WIDTH);
  localparam int MID = PRESCALE / 2;

  rx_state_t             state, state_nxt;
  logic [PW-1:0]         phase;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en_q, stop2_q;
  par_mode_t             par_typ_q;
  logic                  par_bit, stop_bad, any_one, armed;
  logic                  line, fall, bit_maj;
  logic                  decide, start_frame, frame_done, last_data, last_stop;

  uart_rx_sampler #(
    .PRESCALE (PRESCALE),
    .PW       (PW)
  ) u_sampler (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (rx_in),
    .phase   (phase),
    .line    (line),
    .fall    (fall),
    .bit_maj (bit_maj)
  );

  // One bit decision per bit period, at phase MID+1 of the running phase counter.
  assign decide    = (state != ST_IDLE) && (phase == PW'(MID + 1));
  assign last_data = (bit_idx == BW'(DATA_WIDTH - 1));
  assign last_stop = (bit_idx == BW'(stop2_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && fall) begin
          state_nxt   = ST_START;
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        // A high start vote is a glitch: drop back without touching outputs.
        if (decide) state_nxt = bit_maj ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide && last_data) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (decide) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Straight to idle after the last stop vote so a back-to-back start edge is caught.
        if (decide && last_stop) begin
          state_nxt  = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      stop2_q    <= 1'b0;
      par_bit    <= 1'b0;
      stop_bad   <= 1'b0;
      any_one    <= 1'b0;
      armed      <= 1'b1;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_error  <= 1'b0;
      stop_error <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      break_det  <= 1'b0;

      // Parked at 0 in idle, so the start-edge cycle is phase 0 of the start bit.
      if (state_nxt == ST_IDLE || phase == PW'(PRESCALE - 1)) phase <= '0;
      else                                                    phase <= phase + 1'b1;

      // After a low final stop the line must be seen high before a new edge counts.
      if (state == ST_IDLE && line) armed <= 1'b1;

      if (start_frame) begin
        par_en_q  <= par_en;
        par_typ_q <= par_mode_t'(par_typ);
        stop2_q   <= stop2;
        bit_idx   <= '0;
        par_bit   <= 1'b0;
        stop_bad  <= 1'b0;
        any_one   <= 1'b0;
      end

      if (decide) begin
        case (state)
          ST_DATA: begin
            shift   <= {bit_maj, shift[DATA_WIDTH-1:1]};
            any_one <= any_one | bit_maj;
            bit_idx <= last_data ? '0 : bit_idx + 1'b1;
          end
          ST_PARITY: begin
            par_bit <= bit_maj;
            any_one <= any_one | bit_maj;
          end
          ST_STOP: begin
            stop_bad <= stop_bad | ~bit_maj;
            any_one  <= any_one | bit_maj;
            bit_idx  <= bit_idx + 1'b1;
          end
          default: ;
        endcase
      end

      if (frame_done) begin
        p_data     <= shift;
        data_valid <= 1'b1;
        // Received parity bit must equal XOR of data (even) or its inverse (odd).
        par_error  <= par_en_q & (par_bit ^ (^shift) ^ (par_typ_q == PAR_ODD));
        stop_error <= stop_bad | ~bit_maj;
        break_det  <= ~(any_one | bit_maj);
        armed      <= bit_maj;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: two instances (8-bit and 7-bit data, PRESCALE 8).
// Latency: expected data_valid cycle is taken from the frame-length formula.
// Backpressure: none.
module tb_uart_rx_param;

  localparam int P = 8;

  typedef struct {
    int     data;
    bit     perr;
    bit     serr;
    bit     brk;
    longint cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx8 = 1'b1, pe8 = 1'b0, pt8 = 1'b0, s28 = 1'b0;
  logic rx7 = 1'b1, pe7 = 1'b0, pt7 = 1'b0, s27 = 1'b0;
  logic [7:0] pd8;
  logic [6:0] pd7;
  logic dv8, perr8, serr8, brk8;
  logic dv7, perr7, serr7, brk7;

  longint cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q8[$];
  exp_t q7[$];
  exp_t held[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.DATA_WIDTH(8), .PRESCALE(P)) dut8 (
    .clk(clk), .rst(rst), .rx_in(rx8), .par_en(pe8), .par_typ(pt8), .stop2(s28),
    .p_data(pd8), .data_valid(dv8), .par_error(perr8), .stop_error(serr8), .break_det(brk8));

  uart_rx_param #(.DATA_WIDTH(7), .PRESCALE(P)) dut7 (
    .clk(clk), .rst(rst), .rx_in(rx7), .par_en(pe7), .par_typ(pt7), .stop2(s27),
    .p_data(pd7), .data_valid(dv7), .par_error(perr7), .stop_error(serr7), .break_det(brk7));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: what a frame with these line bits must produce, and when.
  function automatic exp_t model(input int dw, input int data, input bit pe, input bit pt,
                                 input bit s2, input bit par_sent, input bit st0, input bit st1,
                                 input longint t0);
    exp_t e;
    int ones;
    ones   = $countones(data);
    e.data = data;
    // total ones including the parity bit: even for even parity, odd for odd parity
    e.perr = pe && (((ones + int'(par_sent)) % 2) != int'(pt));
    e.serr = !st0 || (s2 && !st1);
    e.brk  = (data == 0) && (!pe || !par_sent) && !st0 && (!s2 || !st1);
    e.cyc  = t0 + P / 2 + 2 + longint'(dw + int'(pe) + 1 + int'(s2)) * P;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int inst, input bit v);
    if (inst == 0) rx8 = v;
    else           rx7 = v;
  endtask

  task automatic set_cfg(input int inst, input bit pe, input bit pt, input bit s2);
    if (inst == 0) begin pe8 = pe; pt8 = pt; s28 = s2; end
    else           begin pe7 = pe; pt7 = pt; s27 = s2; end
  endtask

  task automatic push(input int inst, input exp_t e);
    if (inst == 0) q8.push_back(e);
    else           q7.push_back(e);
  endtask

  // Sends one frame; rst_at >= 0 pulses reset in the middle of that bit (no frame expected).
  task automatic send_frame(input int inst, input int data, input bit pe, input bit pt,
                            input bit s2, input bit flip, input bit st0, input bit st1,
                            input int gap, input int rst_at);
    int dw, d;
    bit par_sent;
    bit bits[$];
    longint t0;
    dw = (inst == 0) ? 8 : 7;
    d  = data & ((1 << dw) - 1);
    par_sent = 1'(($countones(d) % 2) ^ int'(pt) ^ int'(flip));
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) bits.push_back(1'((d >> i) & 1));
    if (pe) bits.push_back(par_sent);
    bits.push_back(st0);
    if (s2) bits.push_back(st1);
    set_cfg(inst, pe, pt, s2);
    t0 = cyc + 2;  // two synchroniser flops between rx_in and the line the FSM sees
    if (rst_at < 0) push(inst, model(dw, d, pe, pt, s2, par_sent, st0, st1, t0));
    for (int i = 0; i < bits.size(); i++) begin
      set_line(inst, bits[i]);
      if (i == 1) set_cfg(inst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
      if (i == rst_at) begin
        tick(P / 2);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(P - P / 2 - 2);
      end else begin
        tick(P);
      end
    end
    set_line(inst, 1'b1);
    tick(gap);
  endtask

  task automatic rand_frames(input int inst, input int n);
    for (int k = 0; k < n; k++) begin
      int dw, d, gap;
      bit pe, pt, s2, flip, st0, st1;
      dw   = (inst == 0) ? 8 : 7;
      d    = int'($urandom_range(0, (1 << dw) - 1));
      pe   = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      s2   = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 4) == 0);
      st0  = ($urandom_range(0, 6) != 0);
      st1  = ($urandom_range(0, 6) != 0);
      gap  = int'($urandom_range(0, 2 * P));
      if ($urandom_range(0, 9) == 0) begin
        d = 0; st0 = 1'b0; st1 = 1'b0; flip = pt;  // all-zero break-style frame
      end
      if (!(s2 ? st1 : st0) && gap < P) gap = P;  // line must go high again to re-arm
      send_frame(inst, d, pe, pt, s2, flip, st0, st1, gap, -1);
    end
  endtask

  task automatic mon(input int inst, input logic dv, input int pd, input logic pe,
                     input logic se, input logic bk);
    exp_t e;
    int n;
    string tag;
    tag = (inst == 0) ? "w8" : "w7";
    if (!rst) begin
      chk({tag, "_rst_p_data"}, pd, 0);
      chk({tag, "_rst_data_valid"}, dv, 0);
      chk({tag, "_rst_par_error"}, pe, 0);
      chk({tag, "_rst_stop_error"}, se, 0);
      chk({tag, "_rst_break_det"}, bk, 0);
      held[inst] = '{default: 0};
    end else if (dv) begin
      n = (inst == 0) ? q8.size() : q7.size();
      chk({tag, "_valid_expected"}, longint'(n != 0), 1);
      if (n != 0) begin
        if (inst == 0) e = q8.pop_front();
        else           e = q7.pop_front();
        chk({tag, "_valid_cycle"}, cyc, e.cyc);
        chk({tag, "_p_data"}, pd, e.data);
        chk({tag, "_par_error"}, pe, e.perr);
        chk({tag, "_stop_error"}, se, e.serr);
        chk({tag, "_break_det"}, bk, e.brk);
        held[inst] = e;
      end
    end else begin
      chk({tag, "_hold_p_data"}, pd, held[inst].data);
      chk({tag, "_hold_par_error"}, pe, held[inst].perr);
      chk({tag, "_hold_stop_error"}, se, held[inst].serr);
      chk({tag, "_break_idle"}, bk, 0);
    end
  endtask

  always @(negedge clk) mon(0, dv8, int'(pd8), perr8, serr8, brk8);
  always @(negedge clk) mon(1, dv7, int'(pd7), perr7, serr7, brk7);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(4);

    // 8-bit, even parity, one stop
    send_frame(0, 8'hA5, 1, 0, 0, 0, 1, 1, 2 * P, -1);
    send_frame(0, 8'hA5, 1, 0, 0, 1, 1, 1, 2 * P, -1);  // wrong parity bit
    send_frame(0, 8'h3C, 1, 0, 0, 0, 1, 1, 2 * P, -1);

    // two-cycle glitch while idle must be rejected
    set_line(0, 1'b0);
    tick(2);
    set_line(0, 1'b1);
    tick(3 * P);
    send_frame(0, 8'h55, 1, 0, 0, 0, 1, 1, 2 * P, -1);

    // 7-bit, odd parity, two stops: bad second stop, then back-to-back frames
    send_frame(1, 7'h2A, 1, 1, 1, 0, 1, 0, 2 * P, -1);
    send_frame(1, 7'h12, 1, 1, 1, 0, 1, 1, 0, -1);
    send_frame(1, 7'h6B, 1, 1, 1, 0, 1, 1, 2 * P, -1);

    // line held low for three frame times: exactly one break frame
    set_cfg(0, 1, 0, 0);
    push(0, model(8, 0, 1, 0, 0, 0, 0, 0, cyc + 2));
    set_line(0, 1'b0);
    tick(3 * 11 * P);
    set_line(0, 1'b1);
    tick(2 * P);
    send_frame(0, 8'h5A, 1, 0, 0, 0, 1, 1, 2 * P, -1);

    // reset during the 4th data bit of 0xFF aborts it; next frame is clean
    send_frame(0, 8'hFF, 0, 0, 0, 0, 1, 1, 2 * P, 4);
    send_frame(0, 8'h81, 0, 0, 0, 0, 1, 1, 2 * P, -1);

    fork
      rand_frames(0, 30);
      rand_frames(1, 30);
    join

    for (int k = 0; k < 2000 && (q8.size() != 0 || q7.size() != 0); k++) tick(1);
    chk("w8_drain", q8.size(), 0);
    chk("w7_drain", q7.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL provide parameter PRESCALE, default 16, clk cycles per bit, even, legal range 4..64.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  sampling clock, PRESCALE cycles per bit.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port rx_in  input  1  serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port par_en  input  1  parity bit present when 1.
REQ-008 SHALL have port par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port stop2  input  1  two stop bits when 1, one stop bit when 0.
REQ-010 SHALL have port p_data  output  DATA_WIDTH  received data word, LSB first on the line.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse when a frame completes.
REQ-012 SHALL have port par_error  output  1  parity mismatch for the frame flagged by data_valid.
REQ-013 SHALL have port stop_error  output  1  a stop bit sampled low (framing error).
REQ-014 SHALL have port break_det  output  1  one-cycle pulse when all data bits, parity and stop bits are 0.

Function
REQ-015 SHALL pass rx_in through a 2-flop synchroniser; all behaviour below refers to the synchronised signal.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE, a high-to-low transition on the synchronised line (cycle t0) SHALL move the block to START, clear the bit-phase counter, and latch par_en, par_typ and stop2 for the whole frame.
REQ-018 Each bit value SHALL be the 2-of-3 majority of the samples at phase PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1, decided at phase PRESCALE/2+1.
REQ-019 A START majority of 1 SHALL be a false start: return to IDLE with no output change.
REQ-020 DATA SHALL collect DATA_WIDTH bits LSB first, then go to PARITY if par_en was latched, otherwise to STOP.
REQ-021 Parity SHALL be checked against XOR of the data bits (even) or its inverse (odd).
REQ-022 STOP SHALL check one or two stop bits; any stop bit sampled 0 SHALL set stop_error for that frame.
REQ-023 With F = DATA_WIDTH + par_en + 1 + stop2, data_valid SHALL assert at cycle t0 + PRESCALE/2 + 2 + F*PRESCALE.
REQ-024 p_data, par_error and stop_error SHALL update in the data_valid cycle and hold until the next data_valid.
REQ-025 After the final stop decision the block SHALL enter IDLE immediately, so a start edge half a bit later is accepted (back-to-back frames).
REQ-026 If the final stop bit was 0, IDLE SHALL ignore edges until the line has been sampled high, then re-arm.
REQ-027 break_det SHALL pulse together with data_valid when break conditions hold; stop_error SHALL also be 1.
REQ-028 Changes to par_en, par_typ or stop2 mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-029 While rst = 0 the block SHALL be in IDLE; p_data = 0; data_valid, par_error, stop_error and break_det = 0; synchroniser flops = 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no data_valid, and reception SHALL resume only after a fresh start edge once reset is released.

Structure
REQ-031 State encoding and the parity-mode encoding SHALL be defined as constants in a shared package, uart_pkg.
REQ-032 The synchroniser plus majority sampler SHALL be one sub-module, uart_rx_sampler; the FSM, counters and shift register SHALL be in uart_rx_param.

Verification
REQ-033 DATA_WIDTH=8, PRESCALE=8, even parity, 1 stop, byte 0xA5 with parity 0 -> data_valid at t0+86, p_data=0xA5, par_error=0, stop_error=0.
REQ-034 Same frame with parity bit 1 -> p_data=0xA5, par_error=1; next correct frame 0x3C -> par_error=0.
REQ-035 Low pulse of 2 cycles on rx_in while idle -> no data_valid, block back in IDLE; following frame 0x55 received correctly.
REQ-036 DATA_WIDTH=7, odd parity, stop2=1, second stop bit 0 -> stop_error=1; two back-to-back frames 0x12, 0x6B with no idle gap -> two data_valid pulses, both correct.
REQ-037 Line held low for 3 frame times -> one data_valid with break_det=1, stop_error=1, p_data=0; no further frame until the line returns high.
REQ-038 rst asserted at the 4th data bit of frame 0xFF -> outputs zero, no data_valid; after release a frame 0x81 is received correctly.
